// File: rtl/axi_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI4-Lite arbiter with one transaction in flight at a time.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (answers SLVERR on expiry).
module axi_lite_arbiter_2to1 #(
  parameter int DATA_WIDTH     = 32,
  parameter int RESPONSE_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  // master 0
  input  logic                      m0_awvalid,
  input  logic [DATA_WIDTH-1:0]     m0_awaddr,
  input  logic [2:0]                m0_awprot,
  output logic                      m0_awready,
  input  logic                      m0_wvalid,
  input  logic [DATA_WIDTH-1:0]     m0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m0_wstrb,
  output logic                      m0_wready,
  output logic                      m0_bvalid,
  output logic [RESPONSE_WIDTH-1:0] m0_bresp,
  input  logic                      m0_bready,
  input  logic                      m0_arvalid,
  input  logic [DATA_WIDTH-1:0]     m0_araddr,
  input  logic [2:0]                m0_arprot,
  output logic                      m0_arready,
  output logic                      m0_rvalid,
  output logic [RESPONSE_WIDTH-1:0] m0_rresp,
  output logic [DATA_WIDTH-1:0]     m0_rdata,
  input  logic                      m0_rready,
  // master 1
  input  logic                      m1_awvalid,
  input  logic [DATA_WIDTH-1:0]     m1_awaddr,
  input  logic [2:0]                m1_awprot,
  output logic                      m1_awready,
  input  logic                      m1_wvalid,
  input  logic [DATA_WIDTH-1:0]     m1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   m1_wstrb,
  output logic                      m1_wready,
  output logic                      m1_bvalid,
  output logic [RESPONSE_WIDTH-1:0] m1_bresp,
  input  logic                      m1_bready,
  input  logic                      m1_arvalid,
  input  logic [DATA_WIDTH-1:0]     m1_araddr,
  input  logic [2:0]                m1_arprot,
  output logic                      m1_arready,
  output logic                      m1_rvalid,
  output logic [RESPONSE_WIDTH-1:0] m1_rresp,
  output logic [DATA_WIDTH-1:0]     m1_rdata,
  input  logic                      m1_rready,
  // shared slave
  output logic                      s_awvalid,
  output logic [DATA_WIDTH-1:0]     s_awaddr,
  output logic [2:0]                s_awprot,
  input  logic                      s_awready,
  output logic                      s_wvalid,
  output logic [DATA_WIDTH-1:0]     s_wdata,
  output logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  input  logic [RESPONSE_WIDTH-1:0] s_bresp,
  output logic                      s_bready,
  output logic                      s_arvalid,
  output logic [DATA_WIDTH-1:0]     s_araddr,
  output logic [2:0]                s_arprot,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  input  logic [RESPONSE_WIDTH-1:0] s_rresp,
  input  logic [DATA_WIDTH-1:0]     s_rdata,
  output logic                      s_rready,
  // debug: current FSM state
  output logic [2:0]                dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1; valid never waits on ready.

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [RESPONSE_WIDTH-1:0] SLVERR = RESPONSE_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t state, state_nx;
  logic   gnt, gnt_nx;
  logic   last_gnt, last_gnt_nx;
  logic   aw_done, aw_done_nx;
  logic   w_done, w_done_nx;
  logic   timed_out;

  logic   req0, req1, pick, pick_aw;

  logic                      sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [DATA_WIDTH-1:0]     sel_awaddr, sel_wdata, sel_araddr;
  logic [2:0]                sel_awprot, sel_arprot;
  logic [SW-1:0]             sel_wstrb;

  logic                      g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [RESPONSE_WIDTH-1:0] g_bresp, g_rresp;
  logic [DATA_WIDTH-1:0]     g_rdata;

  assign req0    = m0_awvalid | m0_arvalid;
  assign req1    = m1_awvalid | m1_arvalid;
  // On a tie the master that did not go last wins; otherwise the sole requester.
  assign pick    = (req0 & req1) ? ~last_gnt : req1;
  assign pick_aw = pick ? m1_awvalid : m0_awvalid;

  assign sel_awvalid = gnt ? m1_awvalid : m0_awvalid;
  assign sel_awaddr  = gnt ? m1_awaddr  : m0_awaddr;
  assign sel_awprot  = gnt ? m1_awprot  : m0_awprot;
  assign sel_wvalid  = gnt ? m1_wvalid  : m0_wvalid;
  assign sel_wdata   = gnt ? m1_wdata   : m0_wdata;
  assign sel_wstrb   = gnt ? m1_wstrb   : m0_wstrb;
  assign sel_bready  = gnt ? m1_bready  : m0_bready;
  assign sel_arvalid = gnt ? m1_arvalid : m0_arvalid;
  assign sel_araddr  = gnt ? m1_araddr  : m0_araddr;
  assign sel_arprot  = gnt ? m1_arprot  : m0_arprot;
  assign sel_rready  = gnt ? m1_rready  : m0_rready;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;

  // Zero in IDLE so the first cycle of WR_REQ/RD_REQ counts as 0; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timed_out = (state != IDLE) && (to_cnt == TO_LIMIT);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      aw_done  <= aw_done_nx;
      w_done   <= w_done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    aw_done_nx  = aw_done;
    w_done_nx   = w_done;
    g_awready   = 1'b0;
    g_wready    = 1'b0;
    g_bvalid    = 1'b0;
    g_bresp     = '0;
    g_arready   = 1'b0;
    g_rvalid    = 1'b0;
    g_rresp     = '0;
    g_rdata     = '0;
    s_awvalid   = 1'b0;
    s_awaddr    = '0;
    s_awprot    = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_arprot    = '0;
    s_rready    = 1'b0;

    case (state)
      IDLE: begin
        aw_done_nx = 1'b0;
        w_done_nx  = 1'b0;
        if (req0 | req1) begin
          gnt_nx   = pick;
          state_nx = pick_aw ? WR_REQ : RD_REQ;
        end
      end

      WR_REQ: begin
        if (timed_out) begin
          // Swallow whatever AW/W is still pending, then answer SLVERR.
          g_awready  = ~aw_done;
          g_wready   = ~w_done;
          aw_done_nx = 1'b1;
          w_done_nx  = 1'b1;
          state_nx   = WR_RESP;
        end else begin
          if (!aw_done) begin
            s_awvalid = sel_awvalid;
            s_awaddr  = sel_awaddr;
            s_awprot  = sel_awprot;
            g_awready = s_awready;
            if (sel_awvalid && s_awready) aw_done_nx = 1'b1;
          end
          if (!w_done) begin
            s_wvalid = sel_wvalid;
            s_wdata  = sel_wdata;
            s_wstrb  = sel_wstrb;
            g_wready = s_wready;
            if (sel_wvalid && s_wready) w_done_nx = 1'b1;
          end
          if (aw_done_nx && w_done_nx) state_nx = WR_RESP;
        end
      end

      WR_RESP: begin
        if (timed_out) begin
          g_bvalid = 1'b1;
          g_bresp  = SLVERR;
          if (sel_bready) begin
            last_gnt_nx = gnt;
            state_nx    = IDLE;
          end
        end else begin
          s_bready = sel_bready;
          g_bvalid = s_bvalid;
          g_bresp  = s_bresp;
          if (s_bvalid && sel_bready) begin
            last_gnt_nx = gnt;
            state_nx    = IDLE;
          end
        end
      end

      RD_REQ, RD_DATA: begin
        if (timed_out) begin
          g_rvalid = 1'b1;
          g_rresp  = SLVERR;
          if (sel_rready) begin
            last_gnt_nx = gnt;
            state_nx    = IDLE;
          end
        end else if (state == RD_REQ) begin
          s_arvalid = sel_arvalid;
          s_araddr  = sel_araddr;
          s_arprot  = sel_arprot;
          g_arready = s_arready;
          if (sel_arvalid && s_arready) state_nx = RD_DATA;
        end else begin
          s_rready = sel_rready;
          g_rvalid = s_rvalid;
          g_rresp  = s_rresp;
          g_rdata  = s_rdata;
          if (s_rvalid && sel_rready) begin
            last_gnt_nx = gnt;
            state_nx    = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Only the granted master sees the shared channel; the other reads all zeros.
  assign m0_awready = ~gnt & g_awready;
  assign m0_wready  = ~gnt & g_wready;
  assign m0_bvalid  = ~gnt & g_bvalid;
  assign m0_bresp   = gnt ? '0 : g_bresp;
  assign m0_arready = ~gnt & g_arready;
  assign m0_rvalid  = ~gnt & g_rvalid;
  assign m0_rresp   = gnt ? '0 : g_rresp;
  assign m0_rdata   = gnt ? '0 : g_rdata;

  assign m1_awready = gnt & g_awready;
  assign m1_wready  = gnt & g_wready;
  assign m1_bvalid  = gnt & g_bvalid;
  assign m1_bresp   = gnt ? g_bresp : '0;
  assign m1_arready = gnt & g_arready;
  assign m1_rvalid  = gnt & g_rvalid;
  assign m1_rresp   = gnt ? g_rresp : '0;
  assign m1_rdata   = gnt ? g_rdata : '0;

  assign dbg_state = state;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Directed bench for axi_lite_arbiter_2to1: master drivers, a slave responder,
// and scoreboards for master responses and slave-side requests.
module tb_axi_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [31:0] araddr [2];
  logic [2:0]  awprot [2];
  logic [2:0]  arprot [2];
  logic [3:0]  wstrb  [2];
  wire  [1:0]  awready, wready, bvalid, arready, rvalid;
  wire  [1:0]  bresp [2];
  wire  [1:0]  rresp [2];
  wire  [31:0] rdata [2];

  wire         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  wire  [31:0] s_awaddr, s_wdata, s_araddr;
  wire  [2:0]  s_awprot, s_arprot;
  wire  [3:0]  s_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  wire  [2:0]  dbg_state;

  axi_lite_arbiter_2to1 dut (
    .clk(clk), .reset(reset),
    .m0_awvalid(awvalid[0]), .m0_awaddr(awaddr[0]), .m0_awprot(awprot[0]), .m0_awready(awready[0]),
    .m0_wvalid(wvalid[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bresp(bresp[0]), .m0_bready(bready[0]),
    .m0_arvalid(arvalid[0]), .m0_araddr(araddr[0]), .m0_arprot(arprot[0]), .m0_arready(arready[0]),
    .m0_rvalid(rvalid[0]), .m0_rresp(rresp[0]), .m0_rdata(rdata[0]), .m0_rready(rready[0]),
    .m1_awvalid(awvalid[1]), .m1_awaddr(awaddr[1]), .m1_awprot(awprot[1]), .m1_awready(awready[1]),
    .m1_wvalid(wvalid[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bresp(bresp[1]), .m1_bready(bready[1]),
    .m1_arvalid(arvalid[1]), .m1_araddr(araddr[1]), .m1_arprot(arprot[1]), .m1_arready(arready[1]),
    .m1_rvalid(rvalid[1]), .m1_rresp(rresp[1]), .m1_rdata(rdata[1]), .m1_rready(rready[1]),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rresp(s_rresp), .s_rdata(s_rdata), .s_rready(s_rready),
    .dbg_state(dbg_state)
  );

  wire any_out = |{awready, wready, bvalid, arready, rvalid, bresp[0], bresp[1],
                   rresp[0], rresp[1], rdata[0], rdata[1], s_awvalid, s_awaddr,
                   s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid,
                   s_araddr, s_arprot, s_rready};

  // Scoreboards: master responses {master, is_read, resp, data}; slave requests.
  logic [35:0] exp_q [$];
  logic [31:0] sa_q  [$];
  logic [31:0] sw_q  [$];
  logic [31:0] rd_q  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [35:0] act);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h expected no response", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  // Master response monitor
  always @(negedge clk) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        if (bvalid[m] && bready[m]) pop_check("b_resp", {m[0], 1'b0, bresp[m], 32'h0});
        if (rvalid[m] && rready[m]) pop_check("r_resp", {m[0], 1'b1, rresp[m], rdata[m]});
      end
    end
  end

  // Slave request monitor
  int  aw_hs_cnt = 0, w_hs_cnt = 0;
  int  last_ar_cyc = -1;
  bit  gap_chk = 0;
  bit  m1_track = 0;
  bit  m1_rdy_seen = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (s_awvalid && s_awready) begin
        aw_hs_cnt++;
        if (sa_q.size() == 0) check("s_aw_unexpected", 64'(s_awaddr), 64'hFFFF_FFFF_FFFF);
        else check("s_awaddr", 64'(s_awaddr), 64'(sa_q.pop_front()));
      end
      if (s_wvalid && s_wready) begin
        w_hs_cnt++;
        if (sw_q.size() == 0) check("s_w_unexpected", 64'(s_wdata), 64'hFFFF_FFFF_FFFF);
        else check("s_wdata", 64'(s_wdata), 64'(sw_q.pop_front()));
      end
      if (s_arvalid && s_arready) begin
        if (sa_q.size() == 0) check("s_ar_unexpected", 64'(s_araddr), 64'hFFFF_FFFF_FFFF);
        else check("s_araddr", 64'(s_araddr), 64'(sa_q.pop_front()));
        if (gap_chk && last_ar_cyc >= 0) check("ar_spacing", 64'(cyc - last_ar_cyc), 64'd3);
        last_ar_cyc = cyc;
      end
      if (m1_track) m1_rdy_seen = m1_rdy_seen | awready[1] | wready[1] | arready[1] | bvalid[1] | rvalid[1];
    end
  end

  // Slave responder: always ready for requests, answers one cycle later.
  bit b_block = 0, rd_hang = 0;
  bit sl_aw = 0, sl_w = 0, sl_r = 0;
  always begin
    bit rv_done, bv_done, rst_seen;
    @(negedge clk);
    rst_seen = reset;
    rv_done  = s_rvalid && s_rready;
    bv_done  = s_bvalid && s_bready;
    if (rst_seen) begin
      sl_aw = 0; sl_w = 0; sl_r = 0;
    end else begin
      if (s_awvalid && s_awready) sl_aw = 1;
      if (s_wvalid && s_wready)   sl_w  = 1;
      if (s_arvalid && s_arready) sl_r  = 1;
    end
    @(posedge clk);
    #1;
    if (rst_seen) begin
      s_bvalid = 0; s_rvalid = 0; s_rdata = '0;
    end else begin
      if (rv_done) begin s_rvalid = 0; s_rdata = '0; end
      if (bv_done) s_bvalid = 0;
      if (sl_aw && sl_w && !b_block) begin
        s_bvalid = 1; s_bresp = 2'b00; sl_aw = 0; sl_w = 0;
      end
      if (sl_r && !rd_hang) begin
        s_rvalid = 1; s_rresp = 2'b00; s_rdata = rd_q.pop_front(); sl_r = 0;
      end
    end
  end

  task automatic m_write(input int m, input logic [31:0] a, input logic [31:0] d,
                         input int wdly, input bit wait_b);
    int  t = 0;
    bit  aw_ok = 0, w_ok = 0;
    @(posedge clk); #1;
    awvalid[m] = 1; awaddr[m] = a; awprot[m] = 3'd0;
    if (wdly == 0) begin wvalid[m] = 1; wdata[m] = d; wstrb[m] = 4'hF; end
    while (!(aw_ok && w_ok) && t < 200) begin
      @(negedge clk);
      if (awvalid[m] && awready[m]) aw_ok = 1;
      if (wvalid[m] && wready[m])   w_ok  = 1;
      @(posedge clk); #1;
      t++;
      if (aw_ok) awvalid[m] = 0;
      if (w_ok)  wvalid[m]  = 0;
      if (!w_ok && !wvalid[m] && t >= wdly) begin
        wvalid[m] = 1; wdata[m] = d; wstrb[m] = 4'hF;
      end
    end
    if (t >= 200) check("write_req_bound", 64'(t), 64'd0);
    if (wait_b) begin
      bready[m] = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!bvalid[m] && t < 200);
      if (t >= 200) check("write_resp_bound", 64'(t), 64'd0);
      @(posedge clk); #1;
      bready[m] = 0;
    end
  endtask

  task automatic m_read(input int m, input logic [31:0] a);
    int t = 0;
    @(posedge clk); #1;
    arvalid[m] = 1; araddr[m] = a; arprot[m] = 3'd0;
    do begin @(negedge clk); t++; end while (!arready[m] && t < 200);
    if (t >= 200) check("read_req_bound", 64'(t), 64'd0);
    @(posedge clk); #1;
    arvalid[m] = 0; rready[m] = 1;
    t = 0;
    while (!rvalid[m] && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("read_resp_bound", 64'(t), 64'd0);
    @(posedge clk); #1;
    rready[m] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    int e_cyc, r_cyc;
    int aw0, w0;
    reset = 1;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; wdata[i] = '0; araddr[i] = '0;
      awprot[i] = '0; arprot[i] = '0; wstrb[i] = '0;
    end
    s_awready = 1; s_wready = 1; s_arready = 1;
    s_bvalid = 0; s_rvalid = 0; s_bresp = '0; s_rresp = '0; s_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_outputs", 64'(any_out), 64'd0);

    // Tie right after reset: m0 first, then m1
    rd_q.push_back(32'h11); rd_q.push_back(32'h22);
    sa_q.push_back(32'h4);  sa_q.push_back(32'h8);
    exp_q.push_back({1'b0, 1'b1, 2'b00, 32'h11});
    exp_q.push_back({1'b1, 1'b1, 2'b00, 32'h22});
    fork
      m_read(0, 32'h4);
      m_read(1, 32'h8);
    join

    // m0 write; slave valid lags master valid by one cycle
    sa_q.push_back(32'h10); sw_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back({1'b0, 1'b0, 2'b00, 32'h0});
    m1_track = 1; m1_rdy_seen = 0;
    fork
      m_write(0, 32'h10, 32'hA5A5_A5A5, 0, 1);
      begin
        @(posedge clk); @(negedge clk);
        check("idle_s_awvalid", 64'(s_awvalid), 64'd0);
        check("idle_m0_awready", 64'(awready[0]), 64'd0);
        @(negedge clk);
        check("wr_s_awvalid", 64'(s_awvalid), 64'd1);
        check("wr_s_wstrb", 64'(s_wstrb), 64'hF);
      end
    join
    m1_track = 0;
    check("m1_readies_quiet", 64'(m1_rdy_seen), 64'd0);

    // m1 write with W three cycles behind AW
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    sa_q.push_back(32'h20); sw_q.push_back(32'h0000_BEEF);
    exp_q.push_back({1'b1, 1'b0, 2'b00, 32'h0});
    fork
      m_write(1, 32'h20, 32'h0000_BEEF, 3, 1);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!s_wvalid && t < 50);
        check("lag_state_before_w", 64'(dbg_state), 64'd1);
        check("lag_aw_quiet", 64'(s_awvalid), 64'd0);
        @(negedge clk);
        check("lag_state_after_w", 64'(dbg_state), 64'd2);
      end
    join
    check("lag_aw_count", 64'(aw_hs_cnt - aw0), 64'd1);
    check("lag_w_count", 64'(w_hs_cnt - w0), 64'd1);

    // Back-to-back reads alternate m0, m1 with one IDLE cycle between
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(32'h100 + i); rd_q.push_back(32'h200 + i);
      sa_q.push_back(32'h1000 + i * 4); sa_q.push_back(32'h2000 + i * 4);
      exp_q.push_back({1'b0, 1'b1, 2'b00, 32'h100 + i});
      exp_q.push_back({1'b1, 1'b1, 2'b00, 32'h200 + i});
    end
    last_ar_cyc = -1; gap_chk = 1;
    fork
      for (int i = 0; i < 4; i++) m_read(0, 32'h1000 + i * 4);
      for (int j = 0; j < 4; j++) m_read(1, 32'h2000 + j * 4);
    join
    gap_chk = 0;

    // m0 read so m0 went last; then reset mid-write must restore m0 priority
    rd_q.push_back(32'h44); sa_q.push_back(32'h40);
    exp_q.push_back({1'b0, 1'b1, 2'b00, 32'h44});
    m_read(0, 32'h40);
    b_block = 1;
    sa_q.push_back(32'h50); sw_q.push_back(32'h55);
    m_write(0, 32'h50, 32'h55, 0, 0);
    @(negedge clk);
    check("pre_reset_wr_resp", 64'(dbg_state), 64'd2);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    b_block = 0;
    @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'd0);
    check("midrst_outputs", 64'(any_out), 64'd0);
    rd_q.push_back(32'h66); rd_q.push_back(32'h77);
    sa_q.push_back(32'h60); sa_q.push_back(32'h70);
    exp_q.push_back({1'b0, 1'b1, 2'b00, 32'h66});
    exp_q.push_back({1'b1, 1'b1, 2'b00, 32'h77});
    fork
      m_read(0, 32'h60);
      m_read(1, 32'h70);
    join

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: arbiter returns SLVERR 16 cycles after RD_REQ entry
    rd_hang = 1;
    sa_q.push_back(32'h90);
    exp_q.push_back({1'b1, 1'b1, 2'b10, 32'h0});
    e_cyc = -1; r_cyc = -1;
    fork
      m_read(1, 32'h90);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (dbg_state != 3'd3 && t < 50);
        e_cyc = cyc;
        t = 0;
        do begin @(negedge clk); t++; end while (!rvalid[1] && t < 50);
        r_cyc = cyc;
        check("timeout_latency", 64'(r_cyc - e_cyc), 64'd16);
      end
    join
    @(negedge clk);
    check("timeout_back_idle", 64'(dbg_state), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("addr_queue_empty", 64'(sa_q.size()), 64'd0);
    check("wdata_queue_empty", 64'(sw_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter_2to1.md
Name: axi_lite_arbiter_2to1

Overview:
- Shares one AXI4-Lite slave port between two AXI4-Lite masters (m0, m1) using the team's standard channel set: AW/W/B/AR/R, 32-bit data, 2-bit responses.
- Only one transaction (read or write) is in flight at a time.
- Master selection is round-robin. Sits between the two master engines and the shared slave register block.

Parameters:
- DATA_WIDTH, 32, address and data width.
- RESPONSE_WIDTH, 2, width of bresp/rresp.
- TIMEOUT_CYCLES, 16, watchdog limit. Used only when ARB_TIMEOUT_EN is defined; must be ≥ 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mN_awvalid, mN_awaddr[DATA_WIDTH], mN_awprot[3]  input  (N=0,1)  master write address.
- mN_awready  output  1  master write address ready.
- mN_wvalid, mN_wdata[DATA_WIDTH], mN_wstrb[DATA_WIDTH/8]  input  master write data.
- mN_wready  output  1.
- mN_bvalid  output  1; mN_bresp  output  RESPONSE_WIDTH; mN_bready  input  1.
- mN_arvalid, mN_araddr[DATA_WIDTH], mN_arprot[3]  input; mN_arready  output  1.
- mN_rvalid  output  1; mN_rresp  output  2; mN_rdata  output  DATA_WIDTH; mN_rready  input  1.
- s_awvalid, s_awaddr, s_awprot, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr, s_arprot, s_rready  output  (widths as master side)  slave side.
- s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp, s_rdata  input  slave side.

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA. A registered `gnt` (0/1) selects the master.
- Request definition: reqN = mN_awvalid | mN_arvalid.
- IDLE, selecting the master:
  - If both masters request, pick the one ≠ `last_gnt`; otherwise pick the sole requester.
- IDLE, selecting the direction within the chosen master:
  - If awvalid, go to WR_REQ; else go to RD_REQ.
  - Write has priority over read for the same master.
- IDLE latency: all readies and slave valids are 0 in IDLE. Slave valid asserts the cycle after the master valid is first sampled, so there is no combinational valid→ready path in IDLE.
- WR_REQ:
  - AW and W channels are forwarded combinationally from the granted master to the slave and back, each independently.
  - Flags `aw_done` / `w_done` set on their respective handshakes. Once a flag is set, that channel's s_valid and m_ready are forced to 0.
  - W may lead or lag AW by any number of cycles.
  - When both flags are set (including same-cycle completion), go to WR_RESP.
- WR_RESP:
  - s_bready = granted mN_bready; granted mN_bvalid/bresp = slave.
  - On the b handshake: update `last_gnt` to `gnt`, go to IDLE.
- RD_REQ: AR channel forwarded; on the ar handshake go to RD_DATA.
- RD_DATA:
  - R channel forwarded.
  - On the r handshake: update `last_gnt`, go to IDLE.
- Non-granted master: awready/wready/arready/bvalid/rvalid are 0; bresp/rresp/rdata are 0.
- Slave outputs outside their active state: valids and readies 0; addr/data/strb/prot 0.
- Minimum spacing: one IDLE cycle between consecutive transactions.
- Reset values: state = IDLE, `gnt` = 0, `last_gnt` = 1 (so m0 wins the first tie), `aw_done` = `w_done` = 0, all output valids/readies 0, all output buses 0.
- Reset mid-operation: the transaction is abandoned. All outputs are 0 from the cycle after reset is sampled, and no response is delivered to the master.
- Masters holding valid without a grant are legal and must keep their payload stable (AXI rule); the arbiter performs no buffering.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WR_REQ or RD_REQ and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES, the arbiter stops driving the slave (all s_ valids/readies 0).
  - It then answers the granted master itself: write → mN_bvalid = 1, bresp = 2'b10 (SLVERR); read → mN_rvalid = 1, rresp = 2'b10, rdata = 0.
  - Held until the master's ready; then go to IDLE and update `last_gnt`.
  - If a write times out in WR_REQ, the arbiter first asserts any outstanding m_awready/m_wready for one cycle to consume those channels.
- When undefined: no counter; the arbiter waits indefinitely.

Test Plan:
- m0 write awaddr=0x10, wdata=0xA5A5A5A5, wstrb=0xF, slave returns bresp=00 → s_awvalid rises 1 cycle after m0_awvalid, slave sees 0x10/0xA5A5A5A5, m0_bresp=00, all m1 readies stay 0.
- m0 and m1 both assert arvalid in the first cycle after reset (araddr 0x4 / 0x8), slave rdata=0x11 then 0x22 → m0 served first and gets 0x11; m1 then gets 0x22.
- m1 asserts awvalid (0x20); wvalid follows 3 cycles later → exactly one s_aw handshake and one s_w handshake; WR_RESP entered only after the W handshake.
- m0 and m1 issue 4 reads each, continuously → slave-side grant order m0, m1, m0, m1, …, with one IDLE cycle between transactions.
- Reset asserted for 1 cycle while in WR_RESP with s_bvalid low → next cycle all outputs 0, state IDLE; a subsequent m0/m1 tie goes to m0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts rvalid after an m1 read → m1_rvalid=1 with rresp=2'b10 and rdata=0 at cycle 16 after RD_REQ entry; arbiter returns to IDLE after m1_rready.
